// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage skid buffers: occupancy state
// encoding and the packed entry width helper.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_REG_W  = 4;

  // Occupancy of the 2-entry buffer: nothing held, head only, head + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  // Packed entry layout is {data, write, wr, mem_reg}.
  function automatic int unsigned entry_w(input int unsigned data_w,
                                          input int unsigned reg_w);
    return data_w + reg_w + 2;
  endfunction

  localparam int unsigned DEF_ENTRY_W = DEF_DATA_W + DEF_REG_W + 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear. Holds at
// all-ones instead of wrapping, so long stalls never read back as short.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles, stop at the maximum value.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage boundary buffer: 2-entry skid buffer carrying data plus
// write-back sideband with valid/ready handshake, branch flush and a
// saturating stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned REG_W        = 4,
  parameter logic        FLUSH_MEMREG = 1'b1,
  parameter int unsigned STALL_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_write,
  input  logic [REG_W-1:0]       in_wr,
  input  logic                   in_mem_reg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_write,
  output logic [REG_W-1:0]       out_wr,
  output logic                   out_mem_reg,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned ENTRY_W = entry_w(DATA_W, REG_W);
  localparam logic [ENTRY_W-1:0] BUBBLE = {{(ENTRY_W-1){1'b0}}, FLUSH_MEMREG};

  buf_state_t         r_state;
  buf_state_t         w_state_nxt;
  logic [ENTRY_W-1:0] r_head;
  logic [ENTRY_W-1:0] r_skid;
  logic [ENTRY_W-1:0] w_head_nxt;
  logic [ENTRY_W-1:0] w_skid_nxt;
  logic [ENTRY_W-1:0] w_in_entry;
  logic [ENTRY_W-1:0] w_out_entry;
  logic               r_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_consume;
  logic               w_stall_inc;

  assign w_in_entry  = {in_data, in_write, in_wr, in_mem_reg};
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = in_valid && r_in_ready;
  assign w_consume   = w_out_valid && out_ready;

  // Next occupancy and storage contents from the handshake and flush.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    if (branch) begin
      w_state_nxt = ST_EMPTY;
      w_head_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_head_nxt  = w_in_entry;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_consume) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = w_in_entry;
          end else if (w_accept && w_consume) begin
            w_head_nxt  = w_in_entry;
          end else if (w_consume) begin
            w_state_nxt = ST_EMPTY;
            w_head_nxt  = BUBBLE;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            w_state_nxt = ST_ONE;
            w_head_nxt  = r_skid;
            w_skid_nxt  = BUBBLE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_head_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  // State and storage registers; in_ready is registered from the next state
  // so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_EMPTY;
      r_head     <= BUBBLE;
      r_skid     <= BUBBLE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_head     <= w_head_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  assign w_out_entry = w_out_valid ? r_head : BUBBLE;
  assign {out_data, out_write, out_wr, out_mem_reg} = w_out_entry;
  assign out_valid   = w_out_valid;
  assign in_ready    = r_in_ready;

  assign w_stall_inc = w_out_valid && !out_ready && !branch;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_clr_n (rst),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: a queue scoreboard models the
// buffer contents, every cycle the DUT outputs are compared against it.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          w;
    logic [RW-1:0] r;
    logic          m;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, branch, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          in_write;
  logic [RW-1:0] in_wr;
  logic          in_mem_reg;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_write;
  logic [RW-1:0] out_wr;
  logic          out_mem_reg;
  logic [CW-1:0] stall_cnt;

  ent_t        sb[$];
  int unsigned exp_cnt;
  int          errors;
  int          checks;
  bit          primed;
  bit          saw_dddd;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W       (DW),
    .REG_W        (RW),
    .FLUSH_MEMREG (1'b1),
    .STALL_CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .branch      (branch),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_write    (in_write),
    .in_wr       (in_wr),
    .in_mem_reg  (in_mem_reg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_write   (out_write),
    .out_wr      (out_wr),
    .out_mem_reg (out_mem_reg),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model across the rising edge.
  task automatic step(input logic rstn, input logic br, input logic iv,
                      input logic [DW-1:0] d, input logic w,
                      input logic [RW-1:0] r, input logic m, input logic ordy);
    ent_t e;
    bit   acc, cons;
    rst        = rstn;
    branch     = br;
    in_valid   = iv;
    in_data    = d;
    in_write   = w;
    in_wr      = r;
    in_mem_reg = m;
    out_ready  = ordy;
    #1;
    if (primed) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
      chk("stall_cnt", {29'd0, stall_cnt}, exp_cnt);
      if (sb.size() != 0) begin
        chk("out_data", {16'd0, out_data}, {16'd0, sb[0].d});
        chk("out_write", {31'd0, out_write}, {31'd0, sb[0].w});
        chk("out_wr", {28'd0, out_wr}, {28'd0, sb[0].r});
        chk("out_mem_reg", {31'd0, out_mem_reg}, {31'd0, sb[0].m});
      end else begin
        chk("bub_data", {16'd0, out_data}, 32'd0);
        chk("bub_write", {31'd0, out_write}, 32'd0);
        chk("bub_wr", {28'd0, out_wr}, 32'd0);
        chk("bub_mem_reg", {31'd0, out_mem_reg}, 32'd1);
      end
      if (out_valid && out_data == 16'hDDDD) saw_dddd = 1'b1;
    end
    if (!rstn) begin
      sb.delete();
      exp_cnt = 0;
      primed  = 1'b1;
    end else if (br) begin
      sb.delete();
    end else begin
      acc  = iv && (sb.size() < 2);
      cons = (sb.size() > 0) && ordy;
      if ((sb.size() > 0) && !ordy && (exp_cnt < CNT_MAX)) exp_cnt++;
      if (cons) void'(sb.pop_front());
      if (acc) begin
        e.d = d; e.w = w; e.r = r; e.m = m;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, ordy);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] r,
                      input logic m, input logic ordy);
    step(1'b1, 1'b0, 1'b1, d, 1'b1, r, m, ordy);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    exp_cnt  = 0;
    primed   = 1'b0;
    saw_dddd = 1'b0;

    // Reset held two cycles with upstream presenting an entry.
    step(1'b0, 1'b0, 1'b1, 16'h5A5A, 1'b1, 4'h9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h5A5A, 1'b1, 4'h9, 1'b0, 1'b1);
    idle(1'b1);

    // Streaming at full rate.
    send(16'h1111, 4'd1, 1'b0, 1'b1);
    send(16'h2222, 4'd2, 1'b1, 1'b1);
    send(16'h3333, 4'd3, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: fill, hold a third entry upstream, then drain.
    send(16'hAAAA, 4'hA, 1'b0, 1'b0);
    send(16'hBBBB, 4'hB, 1'b1, 1'b0);
    send(16'hCCCC, 4'hC, 1'b0, 1'b0);
    send(16'hCCCC, 4'hC, 1'b0, 1'b0);
    send(16'hCCCC, 4'hC, 1'b0, 1'b1);
    send(16'hCCCC, 4'hC, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Clear the counter before the flush scenarios.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

    // Flush in FULL with a same-cycle entry that must be discarded.
    send(16'h1234, 4'h4, 1'b0, 1'b0);
    send(16'h5678, 4'h5, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'hDDDD, 1'b1, 4'hD, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("no_dddd", {31'd0, saw_dddd}, 32'd0);

    // Saturation: long stall, branch does not clear, reset does.
    send(16'h7777, 4'h7, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) idle(1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);

    // Reset and branch together while FULL, then one entry after release.
    send(16'h0A0A, 4'h1, 1'b0, 1'b0);
    send(16'h0B0B, 4'h2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'hDDDD, 1'b1, 4'hD, 1'b1, 1'b1);
    send(16'hEEEE, 4'hE, 1'b1, 1'b1);
    send(16'hF00F, 4'hF, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("no_dddd_end", {31'd0, saw_dddd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
